// File: rtl/dmem_pipe_unit.sv
// rtl/dmem_pipe_unit.sv - pipelined RV64/RV32 data-memory stage with valid/ready handshake
// Optional DMEM_PERF_CNT_EN adds saturating load/store/error counters.
module dmem_pipe_unit #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [4:0]      resp_rd,
    output logic            resp_write,
    output logic            resp_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]     perf_loads,
    output logic [31:0]     perf_stores,
    output logic [31:0]     perf_errs
`endif
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] mem [DEPTH];

    logic            advance;
    logic            accept;
    logic [OFFW-1:0] off;
    logic [XLEN-1:0] word_addr;
    logic [AW-1:0]   idx;
    logic [3:0]      nbytes;
    logic [2:0]      amask;
    logic            misaligned;
    logic            out_of_range;
    logic            size_bad;
    logic            err;
    logic [XLEN-1:0] rword;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sgn;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wsh;
    logic [NB-1:0]   lane_en;

    logic [LATENCY-1:0] st_valid;
    logic [LATENCY-1:0] st_write;
    logic [LATENCY-1:0] st_err;
    logic [4:0]         st_rd   [LATENCY];
    logic [XLEN-1:0]    st_data [LATENCY];

    assign advance   = resp_ready | ~resp_valid;
    assign req_ready = advance;
    assign accept    = req_valid & req_ready;

    assign off          = req_addr[OFFW-1:0];
    assign word_addr    = req_addr >> OFFW;
    assign idx          = word_addr[AW-1:0];
    assign nbytes       = 4'd1 << req_size;
    assign amask        = 3'(nbytes - 4'd1);
    assign misaligned   = (req_addr[2:0] & amask) != 3'd0;
    assign out_of_range = word_addr >= XLEN'(DEPTH);
    assign size_bad     = (XLEN == 32) && (req_size == 2'd3);
    assign err          = misaligned | out_of_range | size_bad;

    // Out-of-range reads never touch the array so no X leaks into the extender.
    assign rword   = out_of_range ? '0 : mem[idx];
    assign shifted = rword >> {off, 3'b000};

    always_comb begin
        mask = '1;
        sgn  = shifted[XLEN-1];
        case (req_size)
            2'd0: begin
                mask = XLEN'(8'hFF);
                sgn  = shifted[7];
            end
            2'd1: begin
                mask = XLEN'(16'hFFFF);
                sgn  = shifted[15];
            end
            2'd2: begin
                mask = XLEN'(32'hFFFF_FFFF);
                sgn  = shifted[31];
            end
            default: begin
                mask = '1;
                sgn  = shifted[XLEN-1];
            end
        endcase
        ext = (shifted & mask) | ((sgn & ~req_unsigned) ? ~mask : '0);
    end

    assign load_data = (err | req_write) ? '0 : ext;

    assign wsh = req_wdata << {off, 3'b000};

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < NB; i++) begin
            lane_en[i] = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
        end
    end

    // Array is deliberately outside the reset domain: stores survive a reset.
    always_ff @(posedge clock) begin
        if (accept && req_write && !err) begin
            for (int i = 0; i < NB; i++) begin
                if (lane_en[i]) begin
                    mem[idx][i*8 +: 8] <= wsh[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_valid <= '0;
            st_write <= '0;
            st_err   <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                st_rd[k]   <= '0;
                st_data[k] <= '0;
            end
        end else if (advance) begin
            st_valid[0] <= accept;
            st_write[0] <= accept & req_write;
            st_err[0]   <= accept & err;
            st_rd[0]    <= accept ? req_rd : 5'd0;
            st_data[0]  <= accept ? load_data : '0;
            for (int k = 1; k < LATENCY; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_write[k] <= st_write[k-1];
                st_err[k]   <= st_err[k-1];
                st_rd[k]    <= st_rd[k-1];
                st_data[k]  <= st_data[k-1];
            end
        end
    end

    assign resp_valid = st_valid[LATENCY-1];
    assign resp_write = st_write[LATENCY-1];
    assign resp_err   = st_err[LATENCY-1];
    assign resp_rd    = st_rd[LATENCY-1];
    assign resp_rdata = st_data[LATENCY-1];

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
        end else if (accept) begin
            if (err) begin
                if (perf_errs != 32'hFFFF_FFFF) perf_errs <= perf_errs + 32'd1;
            end else if (req_write) begin
                if (perf_stores != 32'hFFFF_FFFF) perf_stores <= perf_stores + 32'd1;
            end else begin
                if (perf_loads != 32'hFFFF_FFFF) perf_loads <= perf_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dmem_pipe_unit.md
Name: dmem_pipe_unit

Overview:
Parametrised data-memory stage that replaces the inline combinational data-memory array in the 5-stage RV64 datapath. It accepts one load/store request per cycle from the EX/MEM boundary over a valid/ready handshake and returns a response exactly LATENCY cycles later. It adds features the current array lacks: byte/half/word/double access, sign/zero extension, byte-lane stores, alignment and range checking, and backpressure to the pipeline.

Parameters:
XLEN, 64, data width in bits; must be 32 or 64.
DEPTH, 1024, number of XLEN-bit words in the array.
LATENCY, 1, request-to-response cycles; legal range 1..4.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept the request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (3 is illegal when XLEN = 32)
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data; low bytes are used
req_rd  in  5  destination register tag, passed through unchanged
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_rdata  out  XLEN  extended load data; 0 for stores and for errors
resp_rd  out  5  tag of the request being answered
resp_write  out  1  copy of req_write for the request being answered
resp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset (reset = 0, asynchronous): all pipeline valid bits clear.
  - resp_valid, resp_err, resp_write = 0; resp_rdata = 0; resp_rd = 0.
  - Array contents are not reset.
- Accept condition: req_valid & req_ready on a rising edge.
- req_ready = resp_ready | ~resp_valid. This is combinational. No request is accepted while the final stage is full and stalled.
- Error check at accept:
  - err = misaligned | out-of-range.
  - misaligned: address not a multiple of 2^req_size.
  - out-of-range: (req_addr >> log2(XLEN/8)) >= DEPTH.
  - req_size = 3 with XLEN = 32 also counts as an error.
- Store at accept, no error: write only the selected byte lanes of word[addr >> log2(XLEN/8)]. Lanes start at addr[low bits]. Other lanes are unchanged.
- Store at accept, error: the array is not modified.
- Load at accept: read the word on the accept edge and extract the selected lanes.
  - Zero- or sign-extend to XLEN per req_unsigned.
  - On error, the data is forced to 0.
- Ordering: array access happens at accept, in request order. A load accepted the cycle after a store to the same address returns the stored data. No hazard logic is needed.
- Pipeline: LATENCY stages of {valid, write, rd, err, data}.
  - Stage 0 loads at accept. Stage k loads from stage k-1.
  - The final stage drives the resp_* outputs.
  - The whole pipeline advances when resp_ready | ~resp_valid, and holds otherwise.
  - Bubbles propagate as valid = 0.
- Latency: a request accepted at edge N gives resp_valid = 1 after edge N+LATENCY-1, so the response is visible in cycle N+LATENCY, provided there is no backpressure. Throughput is 1 request per cycle.
- Backpressure: while resp_valid & ~resp_ready, all resp_* outputs are held stable and nothing is accepted.
- Reset mid-operation: in-flight requests are dropped with no response. Stores already accepted remain in the array.

Optional Feature:
Macro: DMEM_PERF_CNT_EN.
- Defined: adds output ports perf_loads, perf_stores, perf_errs, each 32 bits.
  - Each counts accepted requests of its kind. Error requests increment perf_errs only.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- LATENCY = 1: store double 0x1122334455667788 to 0x40, then load double from 0x40 on the next cycle -> resp_rdata = 0x1122334455667788, resp_err = 0, resp_rd echoed.
- Store byte 0xF0 to 0x43, then load byte signed and unsigned from 0x43 -> 0xFFFFFFFFFFFFFFF0 and 0x00000000000000F0. A following double load from 0x40 returns 0x11223344F0667788.
- Load half from 0x41 and load double from address 8*DEPTH -> resp_err = 1, resp_rdata = 0. A later load shows the array is unchanged.
- LATENCY = 3: issue 4 back-to-back loads -> 4 responses on consecutive cycles starting 3 cycles after the first accept, in request order.
- Hold resp_ready = 0 for 5 cycles with the pipeline full -> req_ready = 0 and resp_* stable. On release, responses drain 1 per cycle with none lost or duplicated.
- Assert reset with 2 requests in flight -> resp_valid drops to 0 immediately. After release, a load returns data from the pre-reset store. With DMEM_PERF_CNT_EN defined, all counters read 0.
